// File: rtl/serial_word_packer.sv
// Serial-to-parallel word packer with a DEPTH-entry output FIFO and a registered head word.
// Define SERIAL_WORD_PACKER_PARITY_EN to add a trailing even-parity bit per word and the parity_err_o port.
module serial_word_packer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           word_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef SERIAL_WORD_PACKER_PARITY_EN
  ,
  output logic                       parity_err_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH-1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

`ifdef SERIAL_WORD_PACKER_PARITY_EN
  typedef enum logic [0:0] {ST_COLLECT = 1'b0, ST_PARITY = 1'b1} state_t;

  function automatic logic parity_ok(input logic [WIDTH-1:0] w, input logic p);
    return ~(^{w, p});
  endfunction
`else
  typedef enum logic [0:0] {ST_COLLECT = 1'b0} state_t;
`endif

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [WIDTH-1:0]   shift_r, shift_s, shifted_s;
  logic [WIDTH-1:0]   push_word_s;
  logic               push_s, pop_s, accept_s, completing_s, full_s;
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_inc_s;
  logic [OCC_W-1:0]   count_r, count_s;
  logic [WIDTH-1:0]   head_r, head_s;
  logic               valid_r;
  logic [WIDTH-1:0]   mem_r [DEPTH];
`ifdef SERIAL_WORD_PACKER_PARITY_EN
  logic               err_r, err_s;
`endif

  // Handshake: refuse the word-completing bit while the FIFO has no room
  always_comb begin
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    completing_s = (state_r == ST_PARITY);
`else
    completing_s = (state_r == ST_COLLECT) && (bit_cnt_r == LAST_BIT);
`endif
    full_s    = (count_r == FULL_CNT);
    ready_o   = rst_ni & ~flush_i & ~(completing_s & full_s);
    accept_s  = valid_i & ready_o;
    pop_s     = valid_r & word_ready_i;
    shifted_s = MSB_FIRST ? {shift_r[WIDTH-2:0], data_i} : {data_i, shift_r[WIDTH-1:1]};
  end

  // Collector FSM next-state and push decision
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    push_s      = 1'b0;
    push_word_s = shifted_s;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    err_s       = 1'b0;
`endif
    if (flush_i) begin
      state_s   = ST_COLLECT;
      bit_cnt_s = {CNT_W{1'b0}};
      shift_s   = {WIDTH{1'b0}};
    end else if (accept_s) begin
      case (state_r)
        ST_COLLECT: begin
          shift_s = shifted_s;
          if (bit_cnt_r == LAST_BIT) begin
`ifdef SERIAL_WORD_PACKER_PARITY_EN
            state_s = ST_PARITY;
`else
            push_s    = 1'b1;
            bit_cnt_s = {CNT_W{1'b0}};
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end
`ifdef SERIAL_WORD_PACKER_PARITY_EN
        ST_PARITY: begin
          push_word_s = shift_r;
          if (parity_ok(shift_r, data_i)) begin
            push_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          bit_cnt_s = {CNT_W{1'b0}};
          state_s   = ST_COLLECT;
        end
`endif
        default: begin
          state_s   = ST_COLLECT;
          bit_cnt_s = {CNT_W{1'b0}};
          shift_s   = {WIDTH{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FIFO occupancy and next head word; a push never coincides with full
  always_comb begin
    rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + OCC_W'(1);
      2'b01:   count_s = count_r - OCC_W'(1);
      default: count_s = count_r;
    endcase
    if (pop_s) begin
      if (count_r == OCC_W'(1)) begin
        head_s = push_s ? push_word_s : head_r;
      end else begin
        head_s = mem_r[rd_ptr_inc_s];
      end
    end else if (push_s && (count_r == {OCC_W{1'b0}})) begin
      head_s = push_word_s;
    end else begin
      head_s = head_r;
    end
  end

  // Control, pointer and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r   <= ST_COLLECT;
      bit_cnt_r <= {CNT_W{1'b0}};
      shift_r   <= {WIDTH{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {OCC_W{1'b0}};
      head_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      err_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_inc_s;
      count_r   <= count_s;
      head_r    <= head_s;
      valid_r   <= (count_s != {OCC_W{1'b0}});
`ifdef SERIAL_WORD_PACKER_PARITY_EN
      err_r     <= err_s;
`endif
    end
  end

  // FIFO storage; contents are don't-care until pointed at after a push
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_s) mem_r[wr_ptr_r] <= push_word_s;
  end

  assign word_o       = head_r;
  assign word_valid_o = valid_r;
  assign count_o      = count_r;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
  assign parity_err_o = err_r;
`endif

endmodule

// File: tb/tb_serial_word_packer.sv
// Self-checking bench: directed steps plus random traffic, checked against a queue-based model.
module tb_serial_word_packer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int BPW    = WIDTH + 1;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int BPW    = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n, data, valid, flush, word_ready;
  logic ready_m, ready_l, wv_m, wv_l, err_m, err_l;
  logic [WIDTH-1:0] word_m, word_l;
  logic [$clog2(DEPTH+1)-1:0] count_m, count_l;

  int vectors = 0;
  int miscompares = 0;
  logic seen_ready;
  logic after_rst = 1'b0;

  logic             bits_q [$];
  logic [WIDTH-1:0] q_msb  [$];
  logic [WIDTH-1:0] q_lsb  [$];

  always #5 clk = ~clk;

  serial_word_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .ready_o(ready_m),
    .flush_i(flush), .word_o(word_m), .word_valid_o(wv_m), .word_ready_i(word_ready),
    .count_o(count_m)
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    , .parity_err_o(err_m)
`endif
  );

  serial_word_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .ready_o(ready_l),
    .flush_i(flush), .word_o(word_l), .word_valid_o(wv_l), .word_ready_i(word_ready),
    .count_o(count_l)
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    , .parity_err_o(err_l)
`endif
  );

`ifndef SERIAL_WORD_PACKER_PARITY_EN
  assign err_m = 1'b0;
  assign err_l = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check ready before the edge, advance the model, check outputs after the edge.
  task automatic cycle(input logic d, input logic v, input logic f, input logic wr, input logic r);
    logic             exp_ready, do_pop, exp_err;
    logic [WIDTH-1:0] wm, wl;
    int               ones;
    data = d; valid = v; flush = f; word_ready = wr; rst_n = r;
    #1;
    exp_ready = r && !f && !((bits_q.size() == BPW-1) && (q_msb.size() == DEPTH));
    seen_ready = ready_m;
    chk("ready_msb", {31'd0, ready_m}, {31'd0, exp_ready});
    chk("ready_lsb", {31'd0, ready_l}, {31'd0, exp_ready});
    do_pop  = (q_msb.size() != 0) && wr;
    exp_err = 1'b0;
    if (!r) begin
      bits_q.delete(); q_msb.delete(); q_lsb.delete();
      after_rst = 1'b1;
    end else begin
      if (do_pop) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
      end
      if (f) begin
        bits_q.delete();
      end else if (v && exp_ready) begin
        bits_q.push_back(d);
        if (bits_q.size() == BPW) begin
          wm = '0; wl = '0; ones = 0;
          for (int i = 0; i < WIDTH; i++) begin
            wm[WIDTH-1-i] = bits_q[i];
            wl[i]         = bits_q[i];
          end
          for (int i = 0; i < BPW; i++) ones += int'(bits_q[i]);
          if (!PAR_EN || (ones % 2 == 0)) begin
            q_msb.push_back(wm);
            q_lsb.push_back(wl);
            after_rst = 1'b0;
          end else begin
            exp_err = 1'b1;
          end
          bits_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    chk("count_msb", 32'(count_m), 32'(q_msb.size()));
    chk("count_lsb", 32'(count_l), 32'(q_lsb.size()));
    chk("valid_msb", {31'd0, wv_m}, {31'd0, q_msb.size() != 0});
    chk("valid_lsb", {31'd0, wv_l}, {31'd0, q_lsb.size() != 0});
    if (q_msb.size() != 0) begin
      chk("word_msb", 32'(word_m), 32'(q_msb[0]));
      chk("word_lsb", 32'(word_l), 32'(q_lsb[0]));
    end else if (after_rst) begin
      chk("word_msb_rst", 32'(word_m), 32'd0);
      chk("word_lsb_rst", 32'(word_l), 32'd0);
    end
    if (PAR_EN) begin
      chk("perr_msb", {31'd0, err_m}, {31'd0, exp_err});
      chk("perr_lsb", {31'd0, err_l}, {31'd0, exp_err});
    end
    @(negedge clk);
  endtask

  // Sends the first n bits of w MSB first; bit WIDTH (parity builds) is the even parity, optionally flipped.
  task automatic send_word(input logic [WIDTH-1:0] w, input int n, input logic wr, input logic bad_par);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = (i < WIDTH) ? w[WIDTH-1-i] : ((^w) ^ bad_par);
      cycle(b, 1'b1, 1'b0, wr, 1'b1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] w5;
    logic             last_b;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic packing in both bit orders
    send_word(8'hA5, BPW, 1'b1, 1'b0);
    chk("a5_word", 32'(word_m), 32'hA5);
    chk("a5_valid", {31'd0, wv_m}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("a5_popped", 32'(count_m), 32'd0);
    send_word(8'h35, BPW, 1'b0, 1'b0);
    chk("lsb_ac", 32'(word_l), 32'hAC);
    drain();

    // Backpressure with a full FIFO
    for (int k = 1; k <= DEPTH; k++) send_word(WIDTH'(k), BPW, 1'b0, 1'b0);
    chk("full_count", 32'(count_m), 32'(DEPTH));
    w5 = 8'h05;
    last_b = PAR_EN ? ^w5 : w5[0];
    send_word(w5, BPW - 1, 1'b0, 1'b0);
    cycle(last_b, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_stall", {31'd0, seen_ready}, 32'd0);
    chk("head_01", 32'(word_m), 32'h01);
    cycle(last_b, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("pop_no_reenable", {31'd0, seen_ready}, 32'd0);
    cycle(last_b, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("reenable", {31'd0, seen_ready}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      chk("pop_order", 32'(word_m), 32'(k));
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk("drained", 32'(count_m), 32'd0);

    // Flush discards the partial word and beats valid_i
    send_word(8'hE0, 3, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_ready", {31'd0, seen_ready}, 32'd0);
    send_word(8'hFF, BPW, 1'b0, 1'b0);
    chk("flush_ff", 32'(word_m), 32'hFF);
    chk("flush_cnt", 32'(count_m), 32'd1);
    send_word(8'h00, 2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_keeps_fifo", 32'(word_m), 32'hFF);
    drain();

    // Reset mid-word and mid-FIFO
    send_word(8'h11, BPW, 1'b0, 1'b0);
    send_word(8'hF8, 5, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(count_m), 32'd0);
    chk("rst_valid", {31'd0, wv_m}, 32'd0);
    send_word(8'h96, BPW, 1'b0, 1'b0);
    chk("rst_clean", 32'(word_m), 32'h96);
    drain();

`ifdef SERIAL_WORD_PACKER_PARITY_EN
    send_word(8'hA5, BPW, 1'b0, 1'b0);
    chk("par_good_cnt", 32'(count_m), 32'd1);
    chk("par_good_err", {31'd0, err_m}, 32'd0);
    send_word(8'hA5, BPW, 1'b0, 1'b1);
    chk("par_bad_err", {31'd0, err_m}, 32'd1);
    chk("par_bad_cnt", 32'(count_m), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("par_err_pulse", {31'd0, err_m}, 32'd0);
    drain();
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 75),
            1'($urandom_range(0, 99) < 4),
            1'($urandom_range(0, 99) < 40),
            1'($urandom_range(0, 199) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
